// File: rtl/lsu_mem_port_if.sv
// Load/store bus bundle: CPU request/response handshake plus the word-aligned
// data-memory port with byte-lane write enables.
interface lsu_mem_port_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_split;
  logic [ADDR_W-1:0] daddr;
  logic [31:0]       dwdata;
  logic [3:0]        we;
  logic [31:0]       drdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, drdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_split, daddr, dwdata, we
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, drdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_split, daddr, dwdata, we
  );
endinterface

// File: rtl/lsu_mem_port.sv
// Load/store initiator: splits word-straddling accesses into two aligned
// memory cycles, merges the halves and sign/zero-extends load data.
module lsu_mem_port #(
  parameter int ADDR_W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  lsu_mem_port_if.slave  bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC0 = 2'd1;
  localparam logic [1:0] ACC1 = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              rsp_split_q, rsp_split_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              store_q, store_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       lo_q, lo_d;

  logic [1:0]        ofs;
  logic [ADDR_W-1:0] base;
  logic [7:0]        mask;
  logic              split;

  function automatic logic [7:0] lane_mask(input logic [1:0] sz, input logic [1:0] o);
    logic [7:0] m;
    case (sz)
      2'b00:   m = 8'h01;
      2'b01:   m = 8'h03;
      default: m = 8'h0F;
    endcase
    return m << o;
  endfunction

  // pair is {hi, lo}; shift the addressed byte down to lane 0, then extend
  function automatic logic [31:0] extend_load(input logic [63:0] pair, input logic [1:0] o,
                                              input logic [1:0] sz, input logic uns);
    logic [31:0] v;
    v = 32'(pair >> {o, 3'b000});
    case (sz)
      2'b00:   return {{24{~uns & v[7]}}, v[7:0]};
      2'b01:   return {{16{~uns & v[15]}}, v[15:0]};
      default: return v;
    endcase
  endfunction

  assign ofs   = addr_q[1:0];
  assign base  = {addr_q[ADDR_W-1:2], 2'b00};
  assign mask  = lane_mask(size_q, ofs);
  assign split = |mask[7:4];

  always_comb begin
    state_d     = state_q;
    rsp_split_d = rsp_split_q;
    rsp_rdata_d = rsp_rdata_q;
    store_d     = store_q;
    size_d      = size_q;
    uns_d       = uns_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    lo_d        = lo_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          store_d = bus.req_we;
          size_d  = bus.req_size;
          uns_d   = bus.req_unsigned;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          state_d = ACC0;
        end
      end
      ACC0: begin
        lo_d = bus.drdata;
        if (split) begin
          state_d = ACC1;
        end else begin
          state_d     = RESP;
          rsp_split_d = 1'b0;
          rsp_rdata_d = store_q ? 32'h0 : extend_load({32'h0, bus.drdata}, ofs, size_q, uns_q);
        end
      end
      ACC1: begin
        state_d     = RESP;
        rsp_split_d = 1'b1;
        rsp_rdata_d = store_q ? 32'h0 : extend_load({bus.drdata, lo_q}, ofs, size_q, uns_q);
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory port decoded from state and latched request only; write enables are
  // gated by reset so a write pending at the reset edge is never committed.
  always_comb begin
    bus.daddr  = '0;
    bus.dwdata = '0;
    bus.we     = '0;
    case (state_q)
      ACC0: begin
        bus.daddr  = base;
        bus.dwdata = wdata_q << {ofs, 3'b000};
        if (store_q && rst_n) bus.we = mask[3:0];
      end
      ACC1: begin
        bus.daddr  = base + ADDR_W'(4);
        bus.dwdata = wdata_q >> (6'd32 - {1'b0, ofs, 3'b000});
        if (store_q && rst_n) bus.we = mask[7:4];
      end
      default: ;
    endcase
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_split = rsp_split_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rsp_split_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      rsp_split_q <= rsp_split_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    store_q <= store_d;
    size_q  <= size_d;
    uns_q   <= uns_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    lo_q    <= lo_d;
  end
endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port with a little-endian word memory model.
module tb_lsu_mem_port;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lsu_mem_port_if bus ();

  lsu_mem_port dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem [16];
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (bus.we[i]) mem[bus.daddr[5:2]][8*i +: 8] <= bus.dwdata[8*i +: 8];
  end
  assign bus.drdata = mem[bus.daddr[5:2]];

  int n_tests = 0;
  int n_fail  = 0;
  int lat;
  logic [31:0] a0_daddr, a0_dw, a1_daddr, a1_dw, got_rdata;
  logic [3:0]  a0_we, a1_we;
  logic        got_split;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic run_req(input string tag, input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d);
    chk({tag, " ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid    = 1'b1;
    bus.req_we       = w;
    bus.req_size     = sz;
    bus.req_unsigned = u;
    bus.req_addr     = a;
    bus.req_wdata    = d;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_we    = ~w;
    bus.req_addr  = 32'hFFFF_FFF0;
    bus.req_wdata = 32'h5A5A_5A5A;
    lat      = 1;
    a0_daddr = bus.daddr;
    a0_we    = bus.we;
    a0_dw    = bus.dwdata;
    a1_daddr = '0;
    a1_we    = '0;
    a1_dw    = '0;
    chk({tag, " busy"}, 32'(bus.req_ready), 32'd0);
    while (!bus.rsp_valid && lat < 6) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 2 && !bus.rsp_valid) begin
        a1_daddr = bus.daddr;
        a1_we    = bus.we;
        a1_dw    = bus.dwdata;
      end
    end
    got_rdata = bus.rsp_rdata;
    got_split = bus.rsp_split;
    @(posedge clk); #1;
    chk({tag, " pulse"}, 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst ready", 32'(bus.req_ready), 32'd1);
    chk("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("rst rsp_split", 32'(bus.rsp_split), 32'd0);
    chk("rst we", 32'(bus.we), 32'h0);
    chk("rst daddr", bus.daddr, 32'h0);
    chk("rst dwdata", bus.dwdata, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_req("st_w10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
    chk("st_w10 daddr", a0_daddr, 32'h10);
    chk("st_w10 we", 32'(a0_we), 32'hF);
    chk("st_w10 dwdata", a0_dw, 32'hDEAD_BEEF);
    chk("st_w10 rdata", got_rdata, 32'h0);
    chk("st_w10 lat", 32'(lat), 32'd2);

    run_req("ld_w10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("ld_w10 rdata", got_rdata, 32'hDEAD_BEEF);
    chk("ld_w10 split", 32'(got_split), 32'd0);
    chk("ld_w10 lat", 32'(lat), 32'd2);
    chk("ld_w10 we", 32'(a0_we), 32'h0);

    run_req("ld_bs11", 1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
    chk("ld_bs11 rdata", got_rdata, 32'hFFFF_FFBE);
    run_req("ld_bu11", 1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
    chk("ld_bu11 rdata", got_rdata, 32'h0000_00BE);
    run_req("ld_hs12", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    chk("ld_hs12 rdata", got_rdata, 32'hFFFF_DEAD);

    run_req("st_w13", 1'b1, 2'b10, 1'b0, 32'h13, 32'h1122_3344);
    chk("st_w13 a0 daddr", a0_daddr, 32'h10);
    chk("st_w13 a0 we", 32'(a0_we), 32'h8);
    chk("st_w13 a0 dwdata", a0_dw, 32'h4400_0000);
    chk("st_w13 a1 daddr", a1_daddr, 32'h14);
    chk("st_w13 a1 we", 32'(a1_we), 32'h7);
    chk("st_w13 a1 dwdata", a1_dw, 32'h0011_2233);
    chk("st_w13 split", 32'(got_split), 32'd1);

    run_req("ld_w13", 1'b0, 2'b10, 1'b0, 32'h13, 32'h0);
    chk("ld_w13 rdata", got_rdata, 32'h1122_3344);
    chk("ld_w13 split", 32'(got_split), 32'd1);
    chk("ld_w13 lat", 32'(lat), 32'd3);

    run_req("st_h13", 1'b1, 2'b01, 1'b0, 32'h13, 32'h0000_8001);
    chk("st_h13 a0 we", 32'(a0_we), 32'h8);
    chk("st_h13 a1 we", 32'(a1_we), 32'h1);
    chk("st_h13 split", 32'(got_split), 32'd1);
    run_req("ld_hs13", 1'b0, 2'b01, 1'b0, 32'h13, 32'h0);
    chk("ld_hs13 rdata", got_rdata, 32'hFFFF_8001);

    run_req("st_h12", 1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_8001);
    chk("st_h12 we", 32'(a0_we), 32'hC);
    chk("st_h12 dwdata", a0_dw, 32'h8001_0000);
    chk("st_h12 split", 32'(got_split), 32'd0);
    chk("st_h12 lat", 32'(lat), 32'd2);

    run_req("st_wrap", 1'b1, 2'b10, 1'b0, 32'hFFFF_FFFE, 32'hCAFE_F00D);
    chk("st_wrap a0 we", 32'(a0_we), 32'hC);
    chk("st_wrap a1 we", 32'(a1_we), 32'h3);
    run_req("ld_wrap", 1'b0, 2'b10, 1'b0, 32'hFFFF_FFFE, 32'h0);
    chk("ld_wrap a0 daddr", a0_daddr, 32'hFFFF_FFFC);
    chk("ld_wrap a1 daddr", a1_daddr, 32'h0000_0000);
    chk("ld_wrap rdata", got_rdata, 32'hCAFE_F00D);
    chk("ld_wrap split", 32'(got_split), 32'd1);

    run_req("st_w20", 1'b1, 2'b10, 1'b0, 32'h20, 32'h1234_5678);
    run_req("st_w24", 1'b1, 2'b10, 1'b0, 32'h24, 32'h5566_7788);
    run_req("ld_w24", 1'b0, 2'b10, 1'b0, 32'h24, 32'h0);
    chk("ld_w24 rdata", got_rdata, 32'h5566_7788);

    // Split store interrupted by reset while in ACC1
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_size  = 2'b10;
    bus.req_addr  = 32'h21;
    bus.req_wdata = 32'hAABB_CCDD;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("rstmid a0 we", 32'(bus.we), 32'hE);
    @(posedge clk); #1;
    chk("rstmid a1 we", 32'(bus.we), 32'h1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rstmid ready", 32'(bus.req_ready), 32'd1);
    chk("rstmid rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rstmid rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("rstmid we", 32'(bus.we), 32'h0);
    chk("rstmid daddr", bus.daddr, 32'h0);
    chk("rstmid mem20", mem[8], 32'hBBCC_DD78);
    chk("rstmid mem24", mem[9], 32'h5566_7788);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_req("ld_w21", 1'b0, 2'b10, 1'b0, 32'h21, 32'h0);
    chk("ld_w21 rdata", got_rdata, 32'h88BB_CCDD);
    chk("ld_w21 split", 32'(got_split), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
